// File: rtl/reg_writeback_arbiter_if.sv
// Write-back bundle: ALU and long-latency results, scoreboard set/query, register-file write port.
// With OPT_WB_STARVE_GUARD_EN defined the bundle also carries out_alu_hold.
interface reg_writeback_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
);
    // Long-latency handshake: a result transfers on any rising edge where
    // in_lu_valid && out_lu_ready. out_lu_ready never depends on in_lu_valid,
    // and a producer holds sel/data stable while valid is high and not accepted.
    // The ALU path has no ready: every in_alu_valid cycle is taken.
    logic                  in_alu_valid;
    logic [SEL_WIDTH-1:0]  in_alu_sel;
    logic [DATA_WIDTH-1:0] in_alu_data;
    logic                  in_lu_valid;
    logic                  out_lu_ready;
    logic [SEL_WIDTH-1:0]  in_lu_sel;
    logic [DATA_WIDTH-1:0] in_lu_data;
    logic                  in_sb_set_en;
    logic [SEL_WIDTH-1:0]  in_sb_set_sel;
    logic                  out_sb_set_ready;
    logic [SEL_WIDTH-1:0]  in_query_ra;
    logic [SEL_WIDTH-1:0]  in_query_rb;
    logic [SEL_WIDTH-1:0]  in_query_rc;
    logic                  out_busy_ra;
    logic                  out_busy_rb;
    logic                  out_busy_rc;
    logic                  out_write_en;
    logic [SEL_WIDTH-1:0]  out_write_sel;
    logic [DATA_WIDTH-1:0] out_write_data;
`ifdef OPT_WB_STARVE_GUARD_EN
    logic                  out_alu_hold;
`endif

    modport slave (
        input  in_alu_valid, in_alu_sel, in_alu_data,
        input  in_lu_valid, in_lu_sel, in_lu_data,
        input  in_sb_set_en, in_sb_set_sel,
        input  in_query_ra, in_query_rb, in_query_rc,
        output out_lu_ready, out_sb_set_ready,
        output out_busy_ra, out_busy_rb, out_busy_rc,
`ifdef OPT_WB_STARVE_GUARD_EN
        output out_alu_hold,
`endif
        output out_write_en, out_write_sel, out_write_data
    );

    modport master (
        output in_alu_valid, in_alu_sel, in_alu_data,
        output in_lu_valid, in_lu_sel, in_lu_data,
        output in_sb_set_en, in_sb_set_sel,
        output in_query_ra, in_query_rb, in_query_rc,
        input  out_lu_ready, out_sb_set_ready,
        input  out_busy_ra, out_busy_rb, out_busy_rc,
`ifdef OPT_WB_STARVE_GUARD_EN
        input  out_alu_hold,
`endif
        input  out_write_en, out_write_sel, out_write_data
    );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU and buffered long-latency results onto one registered register-file write port,
// and tracks pending writes per register. OPT_WB_STARVE_GUARD_EN enables the ALU-hold starvation guard.
module reg_writeback_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int SEL_WIDTH      = 4,
    parameter int LU_BUF_DEPTH   = 2,
    parameter int PEND_CNT_WIDTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    reg_writeback_arbiter_if.slave  wb
);
    localparam int PTR_W = (LU_BUF_DEPTH > 1) ? $clog2(LU_BUF_DEPTH) : 1;
    localparam int FILL_W = $clog2(LU_BUF_DEPTH + 1);

    typedef logic [PEND_CNT_WIDTH-1:0] pend_t;

    logic [DATA_WIDTH-1:0] buf_data_q [LU_BUF_DEPTH];
    logic [SEL_WIDTH-1:0]  buf_sel_q  [LU_BUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  buf_empty, buf_full, push, pop;

    logic                  wr_en_q, wr_en_d;
    logic [SEL_WIDTH-1:0]  wr_sel_q, wr_sel_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    pend_t                 pend_q [NUM_REGS];
    pend_t                 pend_d [NUM_REGS];
    logic                  sb_ready, set_ok;

    assign buf_empty = (fill_q == '0);
    assign buf_full  = (fill_q == FILL_W'(LU_BUF_DEPTH));
    assign push      = wb.in_lu_valid && !buf_full;
    // Buffer drains only in cycles the ALU leaves the write port free.
    assign pop       = !wb.in_alu_valid && !buf_empty;

    assign wb.out_lu_ready = !buf_full;

    always_comb begin
        fill_d = fill_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Selector 0 is consumed like any other winner but never reaches the register file.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_sel_d  = '0;
        wr_data_d = '0;
        if (wb.in_alu_valid) begin
            if (wb.in_alu_sel != '0) begin
                wr_en_d   = 1'b1;
                wr_sel_d  = wb.in_alu_sel;
                wr_data_d = wb.in_alu_data;
            end
        end else if (!buf_empty) begin
            if (buf_sel_q[rd_ptr_q] != '0) begin
                wr_en_d   = 1'b1;
                wr_sel_d  = buf_sel_q[rd_ptr_q];
                wr_data_d = buf_data_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= wb.in_lu_data;
            buf_sel_q[wr_ptr_q]  <= wb.in_lu_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fill_q    <= fill_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wb.out_write_en   = wr_en_q;
    assign wb.out_write_sel  = wr_sel_q;
    assign wb.out_write_data = wr_data_q;

    // Scoreboard: issue increments, the registered commit decrements, both together cancel.
    assign sb_ready = (pend_q[wb.in_sb_set_sel] != '1);
    assign set_ok   = wb.in_sb_set_en && sb_ready && (wb.in_sb_set_sel != '0);
    assign wb.out_sb_set_ready = sb_ready;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_d[r] = pend_q[r];
            if (r != 0) begin
                if (set_ok && (wb.in_sb_set_sel == SEL_WIDTH'(r)) &&
                    !(wr_en_q && (wr_sel_q == SEL_WIDTH'(r)))) begin
                    pend_d[r] = pend_q[r] + pend_t'(1);
                end else if (wr_en_q && (wr_sel_q == SEL_WIDTH'(r)) &&
                             !(set_ok && (wb.in_sb_set_sel == SEL_WIDTH'(r))) &&
                             (pend_q[r] != '0)) begin
                    pend_d[r] = pend_q[r] - pend_t'(1);
                end
            end else begin
                pend_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
        end
    end

    // Conservative: a commit in flight this cycle still reports busy.
    assign wb.out_busy_ra = (wb.in_query_ra != '0) && (pend_q[wb.in_query_ra] != '0);
    assign wb.out_busy_rb = (wb.in_query_rb != '0) && (pend_q[wb.in_query_rb] != '0);
    assign wb.out_busy_rc = (wb.in_query_rc != '0) && (pend_q[wb.in_query_rc] != '0);

`ifdef OPT_WB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                hold_q, hold_d;

    // Counts cycles the buffer head loses to the ALU; hold stays up until the head finally pops.
    always_comb begin
        starve_d = starve_q;
        hold_d   = hold_q;
        if (pop || buf_empty) begin
            starve_d = '0;
        end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        if (pop) begin
            hold_d = 1'b0;
        end else if (starve_d == STARVE_W'(STARVE_LIMIT)) begin
            hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end

    assign wb.out_alu_hold = hold_q;
`endif

endmodule
